serial_uart: RTL and testbench

Byte-wide 8N1 UART that sits between the host serial pins (`rx`/`tx`) and the serial byte-stream logic feeding the HBA bus master. It converts a runtime-selectable baud rate from a compile-time clock frequency using fractional accumulators, so no exact divisor is required. Received bytes are held with a `valid` flag until a read strobe. Transmit bytes are accepted on a write strobe while the transmitter is not busy.

---
 rtl/serial_uart.sv | 228 ++++++++++++++++++++++
 tb/tb_serial_uart.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_uart.sv
// rtl/serial_uart.sv - byte-wide 8N1 UART with fractional baud-rate accumulators
//
// Purpose: this module sits between the host serial pins and the byte-stream
// logic that feeds the HBA bus master. It derives bit timing from a runtime
// baud rate and the compile-time clock frequency. The timing uses fractional
// accumulators, so CLKFREQ does not need to divide evenly by baud.
//
// Optional feature: define SERIAL_UART_FRAME_CHECK_EN to discard frames whose
// stop bit samples low.
//
// Ports:
//   clk      in   1  single clock, rising edge
//   resetq   in   1  asynchronous active-low reset
//   baud     in  32  bit rate in bit/s (1..921600), sampled every cycle
//   rx       in   1  serial receive line, asynchronous, idle high
//   rd       in   1  read strobe, clears valid
//   wr       in   1  write strobe, starts a frame when not busy
//   tx_data  in   8  byte to send, latched on an accepted wr
//   tx       out  1  serial transmit line, idle high
//   valid    out  1  rx_data holds an unread byte
//   busy     out  1  transmitter is sending a frame
//   rx_data  out  8  last received byte
module serial_uart #(
  parameter int CLKFREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [31:0] baud,
  input  logic        rx,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  tx_data,
  output logic        tx,
  output logic        valid,
  output logic        busy,
  output logic [7:0]  rx_data
);

  localparam logic [32:0] LP_CLK_TX = 33'(CLKFREQ);
  localparam logic [33:0] LP_CLK_RX = 34'(CLKFREQ);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t   r_tx_state;
  logic [32:0] r_tx_acc;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_tx_bit;
  logic        r_tx;
  logic        r_busy;
  logic [32:0] w_tx_sum;
  logic        w_tx_tick;
  logic        w_tx_accept;

  assign w_tx_sum    = r_tx_acc + {1'b0, baud};
  assign w_tx_tick   = (w_tx_sum >= LP_CLK_TX);
  assign w_tx_accept = wr && (r_tx_state == TX_IDLE) && (baud != 32'd0);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tx_state <= TX_IDLE;
      r_tx_acc   <= '0;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      // Clearing on acceptance makes the start bit a full period long.
      if (w_tx_accept)
        r_tx_acc <= '0;
      else if (w_tx_tick)
        r_tx_acc <= w_tx_sum - LP_CLK_TX;
      else
        r_tx_acc <= w_tx_sum;

      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_accept) begin
            r_tx_shift <= tx_data;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tx_tick) begin
            r_busy     <= 1'b0;
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   r_rx_state;
  logic [33:0] r_rx_acc;
  logic [3:0]  r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_valid;
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_prev;
  logic [33:0] w_rx_sum;
  logic        w_rx_tick;
  logic        w_rx_fall;
  logic        w_stop_ok;
  logic        w_rx_done;

  // baud is at most 921600, so 16*baud fits in 34 bits after dropping the top bits.
  assign w_rx_sum  = r_rx_acc + {baud[29:0], 4'b0000};
  assign w_rx_tick = (w_rx_sum >= LP_CLK_RX);
  // Edge detection needs a high-to-low transition. A line held low after a bad
  // stop bit is therefore not taken as a new start until it has gone high first.
  assign w_rx_fall = r_rx_prev && !r_rx_s2;

`ifdef SERIAL_UART_FRAME_CHECK_EN
  assign w_stop_ok = r_rx_s2;
`else
  assign w_stop_ok = 1'b1;
`endif

  assign w_rx_done = (r_rx_state == RX_STOP) && w_rx_tick && (r_rx_cnt == 4'd15) && w_stop_ok;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_rx_state <= RX_IDLE;
      r_rx_acc   <= '0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_valid    <= 1'b0;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;

      if ((r_rx_state == RX_IDLE) && w_rx_fall)
        r_rx_acc <= '0;
      else if (w_rx_tick)
        r_rx_acc <= w_rx_sum - LP_CLK_RX;
      else
        r_rx_acc <= w_rx_sum;

      // A completing byte takes priority over a read in the same cycle.
      if (w_rx_done) begin
        r_rx_data <= r_rx_shift;
        r_valid   <= 1'b1;
      end else if (rd) begin
        r_valid   <= 1'b0;
      end

      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_rx_tick) begin
            if (r_rx_cnt == 4'd7) begin
              // Mid start bit: a high line means it was only a glitch.
              r_rx_cnt   <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'd15) begin
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
              r_rx_bit   <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'd7)
                r_rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (w_rx_tick) begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
            if (r_rx_cnt == 4'd15)
              r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign valid   = r_valid;
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_serial_uart.sv
// tb/tb_serial_uart.sv - scoreboard testbench for serial_uart at 16 clocks per bit
module tb_serial_uart;

  localparam int LP_CLKFREQ = 1_600_000;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [31:0] baud = 32'd100_000;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx;
  logic        valid;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_line;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_q[$];
  int          lat = 155;

  assign rx_line = loop_en ? tx : rx_drv;

  serial_uart #(.CLKFREQ(LP_CLKFREQ)) dut (
    .clk    (clk),
    .resetq (resetq),
    .baud   (baud),
    .rx     (rx_line),
    .rd     (rd),
    .wr     (wr),
    .tx_data(tx_data),
    .tx     (tx),
    .valid  (valid),
    .busy   (busy),
    .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every new byte (valid rising, or rx_data changing while valid) pops one expectation.
  logic       mon_prev_valid = 1'b0;
  logic [7:0] mon_prev_data = 8'h00;
  always @(negedge clk) begin
    if (valid && (!mon_prev_valid || rx_data != mon_prev_data)) begin
      check("rx_pending", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0)
        check("rx_byte", 32'(rx_data), 32'(rx_q.pop_front()));
    end
    mon_prev_valid <= valid;
    mon_prev_data  <= rx_data;
  end

  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    wr = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulse_rd(input string tag);
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check(tag, 32'(valid), 32'd0);
  endtask

  task automatic send_checked(input logic [7:0] b, input bit pulse_ignored);
    logic [9:0] frame;
    int busy_n = 0;
    frame = {1'b1, b, 1'b0};
    accept(b);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (pulse_ignored && i == 50) begin
        tx_data = 8'h3C;
        wr = 1'b1;
      end else begin
        wr = 1'b0;
      end
      check($sformatf("tx_bit%0d", i / 16), 32'(tx), 32'(frame[i / 16]));
      if (busy) busy_n++;
    end
    wr = 1'b0;
    check("busy_cycles", 32'(busy_n), 32'd160);
    @(negedge clk);
    check("busy_end", 32'(busy), 32'd0);
    check("tx_idle_end", 32'(tx), 32'd1);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = frame[i];
      repeat (15) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low_n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    resetq = 1'b1;
    repeat (5) @(negedge clk);

    // wr with baud 0 is ignored
    baud = 32'd0;
    accept(8'h77);
    @(negedge clk);
    check("baud0_busy", 32'(busy), 32'd0);
    check("baud0_tx", 32'(tx), 32'd1);
    baud = 32'd100_000;
    repeat (3) @(negedge clk);

    // 0xA5 waveform with an ignored write of 0x3C mid-frame; loopback also receives it
    rx_q.push_back(8'hA5);
    send_checked(8'hA5, 1'b1);
    low_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (!tx || busy) low_n++;
    end
    check("ignored_wr_activity", 32'(low_n), 32'd0);
    check("a5_valid", 32'(valid), 32'd1);
    check("a5_data", 32'(rx_data), 32'hA5);
    pulse_rd("a5_rd_clear");

    // 0xAC loopback: measure receive latency from acceptance
    rx_q.push_back(8'hAC);
    accept(8'hAC);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 400);
    check("ac_valid_seen", 32'(valid), 32'd1);
    check("ac_latency_window", 32'((n - 1) >= 150 && (n - 1) <= 160), 32'd1);
    if (valid) lat = n - 1;
    check("ac_data", 32'(rx_data), 32'hAC);
    wait_not_busy("ac_tx_done");
    pulse_rd("ac_rd_clear");

    // Overrun: 0x11 then 0x22 without reading
    rx_q.push_back(8'h11);
    accept(8'h11);
    wait_not_busy("x11_tx_done");
    rx_q.push_back(8'h22);
    accept(8'h22);
    wait_not_busy("x22_tx_done");
    repeat (5) @(negedge clk);
    check("overrun_valid", 32'(valid), 32'd1);
    check("overrun_data", 32'(rx_data), 32'h22);

    // rd in the exact completion cycle of 0x56: new byte wins
    rx_q.push_back(8'h56);
    accept(8'h56);
    repeat (lat) @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("collide_valid", 32'(valid), 32'd1);
    check("collide_data", 32'(rx_data), 32'h56);
    @(negedge clk);
    check("collide_valid_hold", 32'(valid), 32'd1);
    wait_not_busy("x56_tx_done");
    pulse_rd("x56_rd_clear");

    // 4-clock low glitch on idle rx
    loop_en = 1'b0;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_valid", 32'(valid), 32'd0);

    // 0x55 with a low stop bit, line held low afterwards
`ifndef SERIAL_UART_FRAME_CHECK_EN
    rx_q.push_back(8'h55);
`endif
    drive_rx_frame(8'h55, 1'b0);
    repeat (32) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
`ifdef SERIAL_UART_FRAME_CHECK_EN
    check("badstop_valid", 32'(valid), 32'd0);
    check("badstop_data", 32'(rx_data), 32'h56);
`else
    check("badstop_valid", 32'(valid), 32'd1);
    check("badstop_data", 32'(rx_data), 32'h55);
`endif

    // Reset in the middle of a frame in both directions
    loop_en = 1'b1;
    accept(8'h99);
    repeat (80) @(negedge clk);
    #2 resetq = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    repeat (20) @(negedge clk);

    // First frame after reset
    rx_q.push_back(8'hF0);
    send_checked(8'hF0, 1'b0);
    repeat (10) @(negedge clk);
    check("f0_valid", 32'(valid), 32'd1);
    check("f0_data", 32'(rx_data), 32'hF0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
